// File: rtl/quant_pkg.sv
// quant_pkg: shared constants and types for the VSQ quantize-stage tile scheduler.
//   ROWS      rows per tile (VSQ buffer depth)
//   AW        VSQ buffer address width
//   TILE_W    tile counter width
//   QUANT_LAT cycles from the quantizer start pulse to its scale-factor valid
//   WDOG      default watchdog limit, cycles from start pulse to error
//   STALL_W   width of the optional backpressure counter
//   state_t   scheduler FSM states
package quant_pkg;
    localparam int ROWS      = 64;
    localparam int AW        = $clog2(ROWS);
    localparam int TILE_W    = 8;
    localparam int QUANT_LAT = 65;
    localparam int WDOG      = 80;
    localparam int STALL_W   = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_START = 3'd2,
        S_QUANT = 3'd3,
        S_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/quant_sched_if.sv
// quant_sched_if: job, row handshake, quantizer and status signals of quant_sched.
//   master modport: the scheduler (drives o_*, dbg_state)
//   slave modport : upstream / quantizer / job controller side
// Row handshake: upstream raises i_acc_valid when a row is present; a row is
// transferred on every rising clock edge where i_acc_valid && o_acc_ready.
// o_acc_ready never depends on i_acc_valid, and upstream must hold a row
// until it is transferred.
interface quant_sched_if;
    import quant_pkg::*;

    logic              i_job_start;
    logic [TILE_W-1:0] i_num_tiles;
    logic              i_acc_valid;
    logic              o_acc_ready;
    logic              o_data_gate;
    logic              o_buf_we;
    logic [AW-1:0]     o_buf_waddr;
    logic              o_q_start;
    logic              i_q_sf_valid;
    logic              o_sf_we;
    logic [TILE_W-1:0] o_tile_idx;
    logic              o_busy;
    logic              o_job_done;
    logic              o_err;
    logic [STALL_W-1:0] o_stall_cnt;
    state_t            dbg_state;

    modport master (
        input  i_job_start, i_num_tiles, i_acc_valid, i_q_sf_valid,
        output o_acc_ready, o_data_gate, o_buf_we, o_buf_waddr, o_q_start,
               o_sf_we, o_tile_idx, o_busy, o_job_done, o_err, o_stall_cnt,
               dbg_state
    );

    modport slave (
        output i_job_start, i_num_tiles, i_acc_valid, i_q_sf_valid,
        input  o_acc_ready, o_data_gate, o_buf_we, o_buf_waddr, o_q_start,
               o_sf_we, o_tile_idx, o_busy, o_job_done, o_err, o_stall_cnt,
               dbg_state
    );
endinterface

// File: rtl/quant_wdog.sv
// quant_wdog: watchdog for the quantizer read-out.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count (asserted in the start-pulse cycle)
//   en       : count while waiting for the quantizer
//   expired  : high in the cycle whose transition lands LIMIT cycles after clr
module quant_wdog
    import quant_pkg::*;
#(
    parameter int LIMIT = WDOG
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    // cnt holds the number of cycles elapsed since the clr cycle, so acting on
    // expired (cnt == LIMIT-1) makes the consequence visible LIMIT cycles later.
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CW'(1);
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == LAST);
endmodule

// File: rtl/quant_sched.sv
// quant_sched: tile scheduler for the VSQ quantize stage.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (master) : job start/size, row handshake, buffer write, quantizer
//                  start / scale-factor valid, tile index, busy/done/err,
//                  stall counter, debug state
// Optional feature: define QUANT_SCHED_PERF_EN to build the saturating
// backpressure counter on o_stall_cnt; otherwise o_stall_cnt is tied to 0.
module quant_sched
    import quant_pkg::*;
(
    input logic           i_clk,
    input logic           i_rst,
    quant_sched_if.master bus
);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    state_t            state, state_nxt;
    logic [AW-1:0]     row_cnt;
    logic [TILE_W-1:0] tile_idx;
    logic [TILE_W-1:0] num_tiles;
    logic              err;

    logic acc_ready, data_gate, q_start, sf_we, job_done;
    logic wd_clr, wd_en, wd_exp;
    logic job_go, accept, last_tile, wd_fire, spurious;

    quant_wdog #(.LIMIT(WDOG)) u_wdog (
        .clk     (i_clk),
        .rst     (i_rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_exp)
    );

    assign job_go    = (state == S_IDLE) && bus.i_job_start;
    assign accept    = acc_ready && bus.i_acc_valid;
    assign last_tile = (tile_idx == num_tiles - TILE_W'(1));
    // A scale-factor valid in the same cycle as expiry counts as completion.
    assign wd_fire   = (state == S_QUANT) && !bus.i_q_sf_valid && wd_exp;
    assign spurious  = bus.i_q_sf_valid && (state != S_QUANT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_ready = 1'b0;
        data_gate = 1'b0;
        q_start   = 1'b0;
        sf_we     = 1'b0;
        job_done  = 1'b0;
        wd_clr    = 1'b0;
        wd_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_job_start) begin
                    state_nxt = (bus.i_num_tiles == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                acc_ready = 1'b1;
                // Gaps pass zeros to the quantizer, which its running max ignores.
                data_gate = bus.i_acc_valid;
                if (bus.i_acc_valid && row_cnt == LAST_ROW) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                q_start   = 1'b1;
                wd_clr    = 1'b1;
                state_nxt = S_QUANT;
            end
            S_QUANT: begin
                wd_en = 1'b1;
                if (bus.i_q_sf_valid) begin
                    sf_we     = 1'b1;
                    state_nxt = last_tile ? S_DONE : S_FILL;
                end else if (wd_exp) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                job_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_cnt   <= '0;
            tile_idx  <= '0;
            num_tiles <= '0;
            err       <= 1'b0;
        end else begin
            if (job_go) begin
                num_tiles <= bus.i_num_tiles;
                tile_idx  <= '0;
                row_cnt   <= '0;
            end else begin
                // ROWS is a power of two, so the last row wraps row_cnt to 0.
                if (accept) begin
                    row_cnt <= row_cnt + 1'b1;
                end
                if (sf_we && !last_tile) begin
                    tile_idx <= tile_idx + 1'b1;
                end
            end
            if (job_go) begin
                err <= 1'b0;
            end
            if (wd_fire || spurious) begin
                err <= 1'b1;
            end
        end
    end

`ifdef QUANT_SCHED_PERF_EN
    logic [STALL_W-1:0] stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || job_go) begin
            stall_cnt <= '0;
        end else if ((state != S_IDLE) && bus.i_acc_valid && !acc_ready
                     && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.o_stall_cnt = stall_cnt;
`else
    assign bus.o_stall_cnt = '0;
`endif

    assign bus.o_acc_ready = acc_ready;
    assign bus.o_data_gate = data_gate;
    assign bus.o_buf_we    = data_gate;
    assign bus.o_buf_waddr = row_cnt;
    assign bus.o_q_start   = q_start;
    assign bus.o_sf_we     = sf_we;
    assign bus.o_tile_idx  = tile_idx;
    assign bus.o_busy      = (state != S_IDLE);
    assign bus.o_job_done  = job_done;
    assign bus.o_err       = err;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_quant_sched.sv
// tb_quant_sched: self-checking bench for quant_sched.
// Drivers push expected output events (buffer write, start pulse, scale-factor
// write, job done) with their cycle numbers into exp_q; a monitor on the
// falling edge pops and compares whenever the DUT presents one of them.
module tb_quant_sched;
    import quant_pkg::*;

    localparam int EV_WE = 1;
    localparam int EV_QS = 2;
    localparam int EV_SF = 3;
    localparam int EV_DN = 4;
    localparam int LOW_PER_TILE = QUANT_LAT + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_q[$];

    quant_sched_if bus();

    quant_sched dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: still running at %0t, required finish", $time);
        $fatal(1, "bench time limit reached");
    end

    // ---------------- scoreboard ----------------
    function automatic logic [31:0] ev(input int kind, input int data, input int c);
        return {kind[3:0], data[7:0], c[19:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon_event(input int kind, input int data);
        logic [31:0] got, want;
        got = ev(kind, data, cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event_unexpected: got kind %0d data %0d cycle %0d, required none",
                     kind, data, cyc);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_bad++;
                $display("FAIL event: got kind %0d data %0d cycle %0d, required kind %0d data %0d cycle %0d",
                         got[31:28], got[27:20], got[19:0], want[31:28], want[27:20], want[19:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_buf_we)   mon_event(EV_WE, int'(bus.o_buf_waddr));
        if (bus.o_q_start)  mon_event(EV_QS, 0);
        if (bus.o_sf_we)    mon_event(EV_SF, int'(bus.o_tile_idx));
        if (bus.o_job_done) mon_event(EV_DN, 0);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"},   32'(bus.o_acc_ready), 0);
        check({tag, "_gate"},    32'(bus.o_data_gate), 0);
        check({tag, "_we"},      32'(bus.o_buf_we), 0);
        check({tag, "_waddr"},   32'(bus.o_buf_waddr), 0);
        check({tag, "_qstart"},  32'(bus.o_q_start), 0);
        check({tag, "_sfwe"},    32'(bus.o_sf_we), 0);
        check({tag, "_tile"},    32'(bus.o_tile_idx), 0);
        check({tag, "_busy"},    32'(bus.o_busy), 0);
        check({tag, "_done"},    32'(bus.o_job_done), 0);
        check({tag, "_err"},     32'(bus.o_err), 0);
        check({tag, "_stall"},   bus.o_stall_cnt, 0);
        check({tag, "_state"},   32'(bus.dbg_state), 32'(S_IDLE));
    endtask

    task automatic start_job(input int n, output int c);
        bus.i_num_tiles = TILE_W'(n);
        bus.i_job_start = 1'b1;
        c = cyc;
        step();
        bus.i_job_start = 1'b0;
    endtask

    // n tiles; gap = percent of fill cycles with no row; bp keeps valid high
    // outside FILL; withhold never returns scale factors; spur_row raises a
    // stray scale-factor valid while that row is pending; rst_at pulses reset
    // that many cycles after the last row of tile 0.
    task automatic run_job(input int n, input int gap, input bit bp, input bit withhold,
                           input int spur_row, input int rst_at);
        int c, t, row, it, low, stall_exp;
        bit v, spur_pend, spur_done;
        spur_pend = 1'b0;
        spur_done = 1'b0;
        t = 0;
        start_job(n, c);
        if (n == 0) begin
            exp_q.push_back(ev(EV_DN, 0, c + 1));
            check("empty_err_clear", 32'(bus.o_err), 0);
            check("empty_no_fill", 32'(bus.o_acc_ready), 0);
            step();
            check("empty_idle", 32'(bus.o_busy), 0);
            return;
        end
        for (int tile = 0; tile < n; tile++) begin
            row = 0;
            it  = 0;
            check("fill_ready_on_entry", 32'(bus.o_acc_ready), 1);
            check("fill_tile_idx", 32'(bus.o_tile_idx), 32'(tile));
            if (tile == 0) check("err_clear_on_start", 32'(bus.o_err), 0);
            while (row < ROWS) begin
                bus.i_q_sf_valid = 1'b0;
                if (spur_pend) begin
                    check("spurious_sets_err", 32'(bus.o_err), 1);
                    spur_pend = 1'b0;
                end
                v = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap);
                bus.i_acc_valid = v;
                if (spur_row == row && !spur_done) begin
                    bus.i_q_sf_valid = 1'b1;
                    spur_done = 1'b1;
                    spur_pend = 1'b1;
                end
                #1;
                check("data_gate", 32'(bus.o_data_gate), 32'(v));
                if (v && bus.o_acc_ready) begin
                    exp_q.push_back(ev(EV_WE, row, cyc));
                    t = cyc;
                    row++;
                end
                it++;
                if (it > 16 * ROWS) begin
                    check("fill_budget_rows", 32'(row), 32'(ROWS));
                    return;
                end
                step();
            end
            exp_q.push_back(ev(EV_QS, 0, t + 1));
            low = 0;
            for (int k = 1; k <= WDOG + 1; k++) begin
                bus.i_acc_valid  = bp;
                bus.i_q_sf_valid = (k == QUANT_LAT + 1) && !withhold;
                if (rst_at != 0 && k == rst_at) rst = 1'b1;
                if (rst_at != 0 && k == rst_at + 1) begin
                    rst = 1'b0;
                    check_zero("rst_mid");
                    return;
                end
                if (!bus.o_acc_ready) low++;
                if (k == QUANT_LAT + 1 && !withhold) begin
                    exp_q.push_back(ev(EV_SF, tile, cyc));
                    if (tile == n - 1) exp_q.push_back(ev(EV_DN, 0, cyc + 1));
                    step();
                    break;
                end
                if (withhold && k == WDOG) begin
                    check("wdog_err_before", 32'(bus.o_err), 0);
                    check("wdog_busy_before", 32'(bus.o_busy), 1);
                end
                if (withhold && k == WDOG + 1) begin
                    check("wdog_err", 32'(bus.o_err), 1);
                    check("wdog_idle", 32'(bus.dbg_state), 32'(S_IDLE));
                    return;
                end
                step();
            end
            check("ready_low_cycles", 32'(low), 32'(LOW_PER_TILE));
        end
        bus.i_acc_valid  = 1'b0;
        bus.i_q_sf_valid = 1'b0;
        step();
        check("job_idle", 32'(bus.o_busy), 0);
`ifdef QUANT_SCHED_PERF_EN
        stall_exp = bp ? LOW_PER_TILE * n : 0;
`else
        stall_exp = 0;
`endif
        check("stall_cnt", bus.o_stall_cnt, 32'(stall_exp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.i_job_start  = 1'b0;
        bus.i_num_tiles  = '0;
        bus.i_acc_valid  = 1'b0;
        bus.i_q_sf_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        step();

        run_job(1, 0, 1'b0, 1'b0, -1, 0);    // single tile, back-to-back rows
        repeat (2) step();
        run_job(3, 50, 1'b0, 1'b0, -1, 0);   // gapped fill, three tiles
        repeat (2) step();
        run_job(2, 0, 1'b1, 1'b0, -1, 0);    // valid held through QUANT
        repeat (2) step();
        run_job(1, 0, 1'b0, 1'b1, -1, 0);    // scale factors withheld
        run_job(0, 0, 1'b0, 1'b0, -1, 0);    // empty job, also clears err
        repeat (2) step();
        run_job(1, 50, 1'b0, 1'b0, 10, 0);   // stray sf_valid during FILL
        check("spurious_err_sticky", 32'(bus.o_err), 1);
        repeat (2) step();
        run_job(1, 0, 1'b0, 1'b0, -1, 30);   // reset mid-QUANT
        repeat (3) step();
        run_job(1, 0, 1'b0, 1'b0, -1, 0);    // normal job after reset

        repeat (4) step();
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/quant_sched.md
# quant_sched

Tile scheduler for the VSQ quantize stage. Gates accumulator rows into the VSQ buffer and the quantizer's running-max path, 64 rows per tile. Fires the quantizer's start pulse and holds upstream off during its 64-cycle read-out. Tracks completion via the quantizer's scale-factor valid, steps tile index and scale-factor store writes, and signals job done or watchdog error.

## Interface
- ROWS, 64: rows per tile; equals VSQ buffer depth.
- AW, 6: buffer address width, log2(ROWS).
- TILE_W, 8: tile counter width.
- WDOG, 80: max cycles from o_q_start to i_q_sf_valid before error.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_job_start  in  1  pulse; latches i_num_tiles; ignored unless IDLE.
- i_num_tiles  in  TILE_W  tiles in job; 0 = empty job.
- i_acc_valid  in  1  upstream row valid.
- o_acc_ready  out  1  row accepted when valid && ready.
- o_data_gate  out  1  high = pass row to quantizer i_data; low = upstream muxes zeros.
- o_buf_we  out  1  VSQ buffer write enable.
- o_buf_waddr  out  AW  VSQ buffer write address.
- o_q_start  out  1  one-cycle start to quantizer.
- i_q_sf_valid  in  1  quantizer scale factors valid; tile done.
- o_sf_we  out  1  write scale factors to store at o_tile_idx.
- o_tile_idx  out  TILE_W  current tile.
- o_busy  out  1  state != IDLE.
- o_job_done  out  1  one-cycle pulse.
- o_err  out  1  sticky; cleared by i_rst or accepted i_job_start.
- o_stall_cnt  out  32  backpressure cycles; see Configuration.

## Operation
- States: IDLE, FILL, START, QUANT, DONE.
- IDLE: o_acc_ready=0. On i_job_start, latch num_tiles, clear tile_idx, row_cnt and o_err. Next state is DONE if num_tiles==0, else FILL.
- FILL:
  - o_acc_ready=1; o_data_gate = o_buf_we = i_acc_valid; o_buf_waddr = row_cnt.
  - row_cnt increments per accepted row.
  - Accepting row ROWS-1 moves to START; row_cnt wraps to 0.
- START: o_q_start=1 for exactly one cycle; ready=0; watchdog cleared; next state QUANT.
- QUANT:
  - ready=0, gate=0; watchdog counts.
  - On i_q_sf_valid: o_sf_we=1 in that cycle. If tile_idx==num_tiles-1, go DONE; else tile_idx++ and go FILL.
  - If the watchdog reaches WDOG first: o_err=1, go IDLE.
- DONE: o_job_done=1 for one cycle; go IDLE.
- Running max ignores zero rows, so the gate-low cycles in FILL never corrupt the max.
- i_q_sf_valid outside QUANT sets o_err=1; state is unchanged.
- i_job_start while busy is ignored.
- tile_idx wraps only via num_tiles; num_tiles = 2^TILE_W-1 is legal.

## Timing
- Reset values: all outputs 0, state IDLE, row_cnt 0, tile_idx 0, o_stall_cnt 0.
- Outputs are combinational from state and registered counters; o_acc_ready has no dependence on i_acc_valid.
- Last row accepted at cycle t: o_q_start high at t+1. Quantizer read-out runs t+2..t+65; i_q_sf_valid expected at t+66, i.e. 65 cycles after o_q_start.
- FILL re-entered the cycle after i_q_sf_valid. The quantizer has cleared its running max by then, so a row may be accepted immediately.
- Minimum tile period: 64 + 1 + 65 + 1 = 131 cycles.
- Reset mid-job: next edge returns to IDLE with no o_job_done. i_rst must be asserted together with the quantizer's reset, otherwise the two blocks desynchronise.

## Configuration
- QUANT_SCHED_PERF_EN defined: o_stall_cnt increments every cycle with o_busy && i_acc_valid && !o_acc_ready. It saturates at 2^32-1 and clears on accepted i_job_start.
- Not defined: o_stall_cnt tied to 0 and no counter logic; the port remains.

## Structure
- Shared package quant_pkg holds:
  - state enum;
  - ROWS;
  - QUANT_LAT = 65;
  - default WDOG;
  - stall counter width.
- One sub-module, quant_wdog: clear, enable, count and expiry at WDOG.
- Row counter and tile counter stay inline.

## Test plan
- Single tile: num_tiles=1, 64 back-to-back valid rows. Required: o_buf_waddr 0..63; o_q_start one cycle after the last row; sf_valid driven 65 cycles later; o_sf_we with tile_idx 0; o_job_done the next cycle.
- Gapped fill, 3 tiles: valid 50% random. Required: o_buf_we only on accepted rows, o_data_gate low on gaps, exactly 3 o_q_start pulses, o_sf_we at tile_idx 0, 1, 2, one o_job_done.
- Backpressure: valid held high through QUANT. Required: ready low for 66 cycles per tile. With QUANT_SCHED_PERF_EN, o_stall_cnt = 66 per tile; without it, 0.
- Watchdog: sf_valid withheld. Required: o_err=1 and IDLE 80 cycles after o_q_start; next i_job_start clears o_err.
- Empty job and spurious sf_valid: num_tiles=0 gives o_job_done 1 cycle after start with no o_q_start. sf_valid in FILL sets o_err with the fill continuing.
- Reset mid-QUANT: i_rst for 1 cycle. Required: all outputs 0 the next cycle, o_job_done never pulses, and a new job runs normally.
